// File: rtl/reg_file_2r2w_if.sv
// Decode/execute bundle for the 2-read/2-write register file: read and write
// addresses, write enables and data toward the file, read operands back.
interface reg_file_2r2w_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] r_a_raddr_in;
  logic [ADDR_W-1:0] r_b_raddr_in;
  logic              r_c_wen_in;
  logic [ADDR_W-1:0] r_c_waddr_in;
  logic [DATA_W-1:0] c_in;
  logic              r_d_wen_in;
  logic [ADDR_W-1:0] r_d_waddr_in;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  // Decode stage side: drives addresses, enables and write data.
  modport master (
    output r_a_raddr_in, r_b_raddr_in,
    output r_c_wen_in, r_c_waddr_in, c_in,
    output r_d_wen_in, r_d_waddr_in, d_in,
    input  a_out, b_out
  );

  // Register file side.
  modport slave (
    input  r_a_raddr_in, r_b_raddr_in,
    input  r_c_wen_in, r_c_waddr_in, c_in,
    input  r_d_wen_in, r_d_waddr_in, d_in,
    output a_out, b_out
  );
endinterface

// File: rtl/reg_file_2r2w.sv
// Flop-based register file with two read ports (A, B) and two write ports
// (C, D); D wins same-address collisions. Optional bypass, zero entry, read register.
module reg_file_2r2w #(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 8,
  parameter  int BYPASS    = 0,
  parameter  int ZERO_REG0 = 0,
  parameter  int READ_REG  = 0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  reg_file_2r2w_if.slave  bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              c_we;
  logic              d_we;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  // With a hard-wired zero entry, writes aimed at address 0 are simply dropped.
  assign c_we = bus.r_c_wen_in && !(ZERO_REG0 != 0 && bus.r_c_waddr_in == '0);
  assign d_we = bus.r_d_wen_in && !(ZERO_REG0 != 0 && bus.r_d_waddr_in == '0);

  // NOTE: storage is flops rather than a RAM macro, so it can and must be
  // cleared on reset; the reset branch overrides any write in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (c_we) mem[bus.r_c_waddr_in] <= bus.c_in;
      // NOTE: the later non-blocking assignment wins when both target the same
      // entry, which is what gives port D priority over port C.
      if (d_we) mem[bus.r_d_waddr_in] <= bus.d_in;
    end
  end

  assign raddr[0] = bus.r_a_raddr_in;
  assign raddr[1] = bus.r_b_raddr_in;

  // Priority, lowest first so each later override wins: stored value,
  // C bypass, D bypass, zero entry.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: rdata gets its stored-value default before any conditional
      // override, so no path leaves it unassigned and no latch is inferred.
      rdata[p] = mem[raddr[p]];
      if (BYPASS != 0 && bus.r_c_wen_in && bus.r_c_waddr_in == raddr[p]) rdata[p] = bus.c_in;
      if (BYPASS != 0 && bus.r_d_wen_in && bus.r_d_waddr_in == raddr[p]) rdata[p] = bus.d_in;
      if (ZERO_REG0 != 0 && raddr[p] == '0) rdata[p] = '0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DATA_W-1:0] a_q;
      logic [DATA_W-1:0] b_q;

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= rdata[0];
          b_q <= rdata[1];
        end
      end

      assign bus.a_out = a_q;
      assign bus.b_out = b_q;
    end else begin : g_read_comb
      assign bus.a_out = rdata[0];
      assign bus.b_out = rdata[1];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_2r2w.sv
// Bench for reg_file_2r2w: four configurations share one stimulus stream and
// are compared against an array-based model, plus directed vectors and sequences.
module tb_reg_file_2r2w;

  logic        clock;
  logic        reset_n;
  logic [4:0]  a_addr, b_addr, c_addr, d_addr;
  logic        c_wen, d_wen;
  logic [31:0] c_data, d_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Configurations: u0 plain, u1 bypass+zero, u2 regread+bypass, u3 regread only.
  localparam int DW_K [4] = '{16, 16, 32, 32};
  localparam int DP_K [4] = '{8, 8, 32, 32};
  localparam bit BP_K [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam bit ZR_K [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit RR_K [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  reg_file_2r2w_if #(.DATA_W(16), .ADDR_W(3)) if0 ();
  reg_file_2r2w_if #(.DATA_W(16), .ADDR_W(3)) if1 ();
  reg_file_2r2w_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
  reg_file_2r2w_if #(.DATA_W(32), .ADDR_W(5)) if3 ();

  assign if0.r_a_raddr_in = a_addr[2:0]; assign if0.r_b_raddr_in = b_addr[2:0];
  assign if0.r_c_wen_in = c_wen; assign if0.r_c_waddr_in = c_addr[2:0]; assign if0.c_in = c_data[15:0];
  assign if0.r_d_wen_in = d_wen; assign if0.r_d_waddr_in = d_addr[2:0]; assign if0.d_in = d_data[15:0];
  assign if1.r_a_raddr_in = a_addr[2:0]; assign if1.r_b_raddr_in = b_addr[2:0];
  assign if1.r_c_wen_in = c_wen; assign if1.r_c_waddr_in = c_addr[2:0]; assign if1.c_in = c_data[15:0];
  assign if1.r_d_wen_in = d_wen; assign if1.r_d_waddr_in = d_addr[2:0]; assign if1.d_in = d_data[15:0];
  assign if2.r_a_raddr_in = a_addr; assign if2.r_b_raddr_in = b_addr;
  assign if2.r_c_wen_in = c_wen; assign if2.r_c_waddr_in = c_addr; assign if2.c_in = c_data;
  assign if2.r_d_wen_in = d_wen; assign if2.r_d_waddr_in = d_addr; assign if2.d_in = d_data;
  assign if3.r_a_raddr_in = a_addr; assign if3.r_b_raddr_in = b_addr;
  assign if3.r_c_wen_in = c_wen; assign if3.r_c_waddr_in = c_addr; assign if3.c_in = c_data;
  assign if3.r_d_wen_in = d_wen; assign if3.r_d_waddr_in = d_addr; assign if3.d_in = d_data;

  reg_file_2r2w #(.DATA_W(16), .DEPTH(8), .BYPASS(0), .ZERO_REG0(0), .READ_REG(0))
    u0 (.clock(clock), .reset_n(reset_n), .bus(if0.slave));
  reg_file_2r2w #(.DATA_W(16), .DEPTH(8), .BYPASS(1), .ZERO_REG0(1), .READ_REG(0))
    u1 (.clock(clock), .reset_n(reset_n), .bus(if1.slave));
  reg_file_2r2w #(.DATA_W(32), .DEPTH(32), .BYPASS(1), .ZERO_REG0(0), .READ_REG(1))
    u2 (.clock(clock), .reset_n(reset_n), .bus(if2.slave));
  reg_file_2r2w #(.DATA_W(32), .DEPTH(32), .BYPASS(0), .ZERO_REG0(0), .READ_REG(1))
    u3 (.clock(clock), .reset_n(reset_n), .bus(if3.slave));

  logic [31:0] out_a [4];
  logic [31:0] out_b [4];
  assign out_a[0] = {16'h0, if0.a_out}; assign out_b[0] = {16'h0, if0.b_out};
  assign out_a[1] = {16'h0, if1.a_out}; assign out_b[1] = {16'h0, if1.b_out};
  assign out_a[2] = if2.a_out;          assign out_b[2] = if2.b_out;
  assign out_a[3] = if3.a_out;          assign out_b[3] = if3.b_out;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [31:0] mem_m [4][32];
  logic [31:0] oa_m [4];
  logic [31:0] ob_m [4];
  bit          model_valid = 1'b0;

  function automatic logic [4:0] amask(input int k);
    return (DP_K[k] == 8) ? 5'd7 : 5'd31;
  endfunction

  function automatic logic [31:0] dmask(input int k);
    return (DW_K[k] == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Value a read of address ra selects this cycle, from the priority rules.
  function automatic logic [31:0] sel(input int k, input logic [4:0] ra);
    logic [4:0] ad = ra & amask(k);
    if (ZR_K[k] && ad == 5'd0) return 32'h0;
    if (BP_K[k] && d_wen && (d_addr & amask(k)) == ad) return d_data & dmask(k);
    if (BP_K[k] && c_wen && (c_addr & amask(k)) == ad) return c_data & dmask(k);
    return mem_m[k][ad];
  endfunction

  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) mem_m[k][i] = 32'h0;
        oa_m[k] = 32'h0;
        ob_m[k] = 32'h0;
      end else begin
        logic [4:0] ca = c_addr & amask(k);
        logic [4:0] da = d_addr & amask(k);
        oa_m[k] = sel(k, a_addr);
        ob_m[k] = sel(k, b_addr);
        if (c_wen && !(ZR_K[k] && ca == 5'd0)) mem_m[k][ca] = c_data & dmask(k);
        if (d_wen && !(ZR_K[k] && da == 5'd0)) mem_m[k][da] = d_data & dmask(k);
      end
    end
    if (!reset_n) model_valid = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    if (model_valid) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("model u%0d a_out", k), out_a[k], RR_K[k] ? oa_m[k] : sel(k, a_addr));
        check($sformatf("model u%0d b_out", k), out_b[k], RR_K[k] ? ob_m[k] : sel(k, b_addr));
      end
    end
  endtask

  // One cycle: outputs are compared at the falling edge, model advances at the rising edge.
  task automatic to_negedge();
    @(negedge clock);
    model_check();
  endtask

  task automatic to_posedge();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic rst, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                        input logic dw, input logic [4:0] da, input logic [31:0] dd,
                        input logic [4:0] ra, input logic [4:0] rb);
    reset_n = rst; c_wen = cw; c_addr = ca; c_data = cd;
    d_wen = dw; d_addr = da; d_data = dd; a_addr = ra; b_addr = rb;
  endtask

  // ---------------- directed vectors for u0 (16x8, no bypass, combinational) ----------------
  typedef struct {
    logic        rst;
    logic        cw;
    logic [4:0]  ca;
    logic [31:0] cd;
    logic        dw;
    logic [4:0]  da;
    logic [31:0] dd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        chk;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [14];

  initial begin
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    tbl[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 32'h0,    32'h0};
    tbl[1]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd1, 32'hFFFFFFFF, 5'd0, 5'd1, 1'b1, 32'h0,    32'h0};
    tbl[2]  = '{1'b1, 1'b1, 5'd2, 32'hFFFFFFFF, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd2, 5'd3, 1'b1, 32'h0,    32'h0};
    tbl[3]  = '{1'b1, 1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, 5'd5, 32'hFFFFFFFF, 5'd4, 5'd5, 1'b1, 32'h0,    32'h0};
    tbl[4]  = '{1'b1, 1'b1, 5'd6, 32'hFFFFFFFF, 1'b1, 5'd7, 32'hFFFFFFFF, 5'd6, 5'd7, 1'b1, 32'h0,    32'h0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 32'hFFFF, 32'hFFFF};
    tbl[6]  = '{1'b1, 1'b1, 5'd3, 32'h1234,     1'b1, 5'd5, 32'hABCD,     5'd0, 5'd1, 1'b1, 32'h0,    32'h0};
    tbl[7]  = '{1'b1, 1'b1, 5'd2, 32'h1111,     1'b1, 5'd2, 32'h2222,     5'd3, 5'd5, 1'b1, 32'h1234, 32'hABCD};
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd2, 5'd4, 1'b1, 32'h2222, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h5A5A,     5'd6, 5'd7, 1'b1, 32'h0,    32'h0};
    tbl[10] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd6, 5'd5, 1'b1, 32'h5A5A, 32'hABCD};
    tbl[11] = '{1'b0, 1'b1, 5'd7, 32'h7777,     1'b0, 5'd0, 32'h0,        5'd7, 5'd6, 1'b1, 32'h0,    32'h5A5A};
    tbl[12] = '{1'b1, 1'b1, 5'd1, 32'h4242,     1'b0, 5'd0, 32'h0,        5'd6, 5'd7, 1'b1, 32'h0,    32'h0};
    tbl[13] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 1'b1, 32'h4242, 32'h0};

    #1;
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].rst, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dw, tbl[i].da, tbl[i].dd,
             tbl[i].ra, tbl[i].rb);
      to_negedge();
      if (tbl[i].chk) begin
        check($sformatf("vec%0d u0 a_out", i), out_a[0], tbl[i].ea);
        check($sformatf("vec%0d u0 b_out", i), out_b[0], tbl[i].eb);
      end
      to_posedge();
    end

    // Same-cycle bypass on u1 versus registered-next-cycle visibility on u0.
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h5A5A, 5'd6, 5'd6);
    to_negedge();
    check("bypass u1 same cycle", out_a[1], 32'h5A5A);
    check("no bypass u0 same cycle", out_a[0], 32'h0);
    to_posedge();
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd6);
    to_negedge();
    check("no bypass u0 next cycle", out_a[0], 32'h5A5A);
    to_posedge();

    // Zero entry: write to 0 with bypass enabled still reads 0.
    set_in(1'b1, 1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    to_negedge();
    check("zero reg u1 same cycle", out_a[1], 32'h0);
    to_posedge();
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    to_negedge();
    check("zero reg u1 next cycle", out_a[1], 32'h0);
    check("u0 entry0 written", out_a[0], 32'hBEEF);
    to_posedge();

    // Registered read: write 31 and read 31 in cycle N.
    set_in(1'b1, 1'b1, 5'd31, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    to_negedge();
    to_posedge();
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    to_negedge();
    check("rreg bypass u2 N+1", out_a[2], 32'hDEADBEEF);
    check("rreg no bypass u3 N+1", out_a[3], 32'h0);
    to_posedge();
    to_negedge();
    check("rreg no bypass u3 N+2", out_a[3], 32'hDEADBEEF);
    to_posedge();

    // Reset asserted alongside a write to 31: write lost, outputs cleared.
    set_in(1'b0, 1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    to_negedge();
    to_posedge();
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
    to_negedge();
    check("reset clears u2 a_out", out_a[2], 32'h0);
    check("reset clears u3 a_out", out_a[3], 32'h0);
    to_posedge();
    to_negedge();
    check("entry31 after reset u2", out_a[2], 32'h0);
    check("entry31 after reset u3", out_a[3], 32'h0);
    to_posedge();

    // Randomised traffic with forced collisions and occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ca, da, ra, rb;
      ca = 5'($urandom_range(0, 31));
      da = ($urandom_range(0, 3) == 0) ? ca : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? da : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? ca : 5'($urandom_range(0, 31));
      set_in(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), ca, $urandom,
             1'($urandom_range(0, 1)), da, $urandom, ra, rb);
      to_negedge();
      to_posedge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r2w.md
# reg_file_2r2w

Parametrised multi-port register file for the datapath: two read ports (A, B) and two write ports (C, D), all on one clock. It generalises the 8x16, 1-read/1-write register file in width and depth and adds:
- a second port of each kind
- a defined write-write collision priority
- optional write-to-read bypass
- optional hard-wired zero entry
- optional registered read outputs

It sits between the decode stage (addresses and enables) and the execute stage (operands, results).

## Interface
Parameters:
- DATA_W, 16, entry width in bits (1..64)
- DEPTH, 8, number of entries; power of two, 2..256
- ADDR_W, log2(DEPTH), address width; derived, not overridden
- BYPASS, 0, 1 = a read of an address being written this cycle returns the write data
- ZERO_REG0, 0, 1 = entry 0 always reads 0 and writes to it are discarded
- READ_REG, 0, 0 = combinational read outputs; 1 = registered read outputs (1-cycle latency)

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset
- r_a_raddr_in  in  ADDR_W  read address, port A
- r_b_raddr_in  in  ADDR_W  read address, port B
- r_c_wen_in  in  1  write enable, port C
- r_c_waddr_in  in  ADDR_W  write address, port C
- c_in  in  DATA_W  write data, port C
- r_d_wen_in  in  1  write enable, port D (higher priority)
- r_d_waddr_in  in  ADDR_W  write address, port D
- d_in  in  DATA_W  write data, port D
- a_out  out  DATA_W  read data, port A
- b_out  out  DATA_W  read data, port B

## Operation
- Storage: DEPTH x DATA_W flops, no RAM macro.
- Reset: reset_n low at a rising edge clears every entry to 0. When READ_REG=1 it also clears a_out and b_out to 0. Reset overrides any write in the same cycle.
- Write: at a rising edge with reset_n high:
  - r_c_wen_in=1 loads entry[r_c_waddr_in] with c_in.
  - r_d_wen_in=1 loads entry[r_d_waddr_in] with d_in.
  - Entries not addressed by an enabled port hold their value.
- Collision: both enables high with equal addresses → d_in is stored and c_in is dropped. No error flag.
- ZERO_REG0=1: writes to address 0 are ignored and reads of address 0 return 0, with or without bypass.
- Read value per port, highest priority first:
  1. ZERO_REG0=1 and address 0 → 0.
  2. BYPASS=1 and r_d_wen_in=1 and address equals r_d_waddr_in → d_in.
  3. BYPASS=1 and r_c_wen_in=1 and address equals r_c_waddr_in → c_in.
  4. Otherwise → the stored entry.
- Ports A and B are independent and may use the same address. Every address is valid; no out-of-range case exists.
- READ_REG=0: a_out/b_out are combinational from the selected value.
- READ_REG=1: a_out/b_out load the selected value at each rising edge with reset_n high.

## Timing
- Write latency: data is stored at the edge ending the write cycle.
  - BYPASS=0, READ_REG=0: a read in the following cycle shows it.
  - BYPASS=1, READ_REG=0: a same-cycle read shows it combinationally.
- READ_REG=1: the address presented in cycle N appears on the output in cycle N+1.
  - BYPASS=1: the N+1 output includes writes issued in cycle N.
  - BYPASS=0: a same-cycle write is not included; the next read sees it.
- Reset is synchronous: it takes effect only at a rising edge. Before the first reset edge, contents are undefined.
- READ_REG=0 during reset: outputs track the cleared contents from the first reset edge onward.
- Reset mid-stream: a write presented in a reset cycle is lost. Writes in the first cycle with reset_n high are accepted.
- No stall or handshake: a write is committed every cycle its enable is high.

## Test plan
- Reset and default read: DATA_W=16, DEPTH=8. Write 0xFFFF to all entries, pulse reset_n low for 1 cycle, then read all addresses on A and B → every read returns 0x0000.
- Basic write/read: write 0x1234 to address 3 via C and 0xABCD to address 5 via D in the same cycle. Next cycle read A=3, B=5 → a_out=0x1234, b_out=0xABCD.
- Collision: C and D both write address 2 (C 0x1111, D 0x2222). Next cycle read 2 → 0x2222.
- Bypass: BYPASS=1. D writes 0x5A5A to address 6 while A reads 6 in the same cycle → a_out=0x5A5A that cycle. With BYPASS=0 and a prior value of 0x0000, the same stimulus gives a_out=0x0000, then 0x5A5A next cycle.
- Zero entry: ZERO_REG0=1. Write 0xBEEF to address 0 via C with BYPASS=1; read 0 on A in the same and next cycle → a_out=0x0000 both cycles.
- Registered read and reset mid-stream: READ_REG=1, DATA_W=32, DEPTH=32.
  - Write 0xDEADBEEF to address 31 and present r_a_raddr_in=31 in cycle N → a_out=0xDEADBEEF in cycle N+1 with BYPASS=1, and in cycle N+2 with BYPASS=0.
  - Assert reset_n low alongside a write to address 31 → a_out=0 after that edge, and entry 31 reads 0 afterward.
